// File: rtl/sram_regfile_sequencer.sv
`timescale 1ns/1ps
// sram_regfile_sequencer: a single start command runs one of three jobs.
//   FILL  - write a descending pattern into the whole SRAM
//   LOAD  - copy one 2^REG_AW-word SRAM block into the register file
//   DUMP  - stream register pairs (r[i], r[i+half]) over a valid/ready port
// All memory/regfile controls are decoded from the state and the index
// counter. dump_a/dump_b and err are registered.
module sram_regfile_sequencer #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [1:0]               cmd,
  input  logic [ADDR_W-REG_AW-1:0] block,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic                     n_mem_oe,
  output logic                     n_mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     rf_we,
  output logic [REG_AW-1:0]        rf_wsel,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic [REG_AW-1:0]        rf_rsel1,
  output logic [REG_AW-1:0]        rf_rsel2,
  input  logic [DATA_W-1:0]        rf_rdata1,
  input  logic [DATA_W-1:0]        rf_rdata2,
  output logic                     dump_valid,
  input  logic                     dump_ready,
  output logic [DATA_W-1:0]        dump_a,
  output logic [DATA_W-1:0]        dump_b
);

  localparam int BLK_W = ADDR_W - REG_AW;
  localparam logic [ADDR_W-1:0] FILL_LAST = '1;
  localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'((1 << REG_AW) - 1);
  localparam logic [ADDR_W-1:0] DUMP_LAST = ADDR_W'((1 << (REG_AW - 1)) - 1);
  localparam logic [REG_AW-1:0] HALF      = REG_AW'(1 << (REG_AW - 1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_LOAD,
    S_LOAD_DRAIN,
    S_DUMP_SEL,
    S_DUMP_OUT,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  idx, idx_nxt;
  logic [BLK_W-1:0]   blk_q;
  logic               err_q;
  logic               accept;

  assign accept = (state == S_IDLE) && start;

  // State and index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Command-side registers: block latch, err pulse, dump pair capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_q  <= '0;
      err_q  <= 1'b0;
      dump_a <= '0;
      dump_b <= '0;
    end else begin
      if (accept) blk_q <= block;
      err_q <= accept && (cmd == 2'b11);
      if (state == S_DUMP_SEL) begin
        dump_a <= rf_rdata1;
        dump_b <= rf_rdata2;
      end
    end
  end

  // Next-state and index-counter logic.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        idx_nxt = '0;
        if (start) begin
          case (cmd)
            2'b00:   state_nxt = S_FILL;
            2'b01:   state_nxt = S_LOAD;
            2'b10:   state_nxt = S_DUMP_SEL;
            default: state_nxt = S_IDLE;
          endcase
        end
      end
      S_FILL: begin
        idx_nxt = idx + ADDR_W'(1);
        if (idx == FILL_LAST) state_nxt = S_DONE;
      end
      S_LOAD: begin
        idx_nxt = idx + ADDR_W'(1);
        if (idx == LOAD_LAST) state_nxt = S_LOAD_DRAIN;
      end
      S_LOAD_DRAIN: state_nxt = S_DONE;
      S_DUMP_SEL:   state_nxt = S_DUMP_OUT;
      S_DUMP_OUT: begin
        if (dump_ready) begin
          if (idx == DUMP_LAST) begin
            state_nxt = S_DONE;
          end else begin
            idx_nxt   = idx + ADDR_W'(1);
            state_nxt = S_DUMP_SEL;
          end
        end
      end
      S_DONE: begin
        idx_nxt   = '0;
        state_nxt = S_IDLE;
      end
      default: begin
        idx_nxt   = '0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from state and index.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    n_mem_oe   = 1'b1;
    n_mem_we   = 1'b1;
    mem_addr   = '0;
    mem_wdata  = '0;
    rf_we      = 1'b0;
    rf_wsel    = '0;
    rf_wdata   = '0;
    rf_rsel1   = '0;
    rf_rsel2   = '0;
    dump_valid = 1'b0;
    case (state)
      S_FILL: begin
        busy      = 1'b1;
        n_mem_we  = 1'b0;
        mem_addr  = idx;
        mem_wdata = DATA_W'(FILL_LAST - idx);
      end
      S_LOAD: begin
        busy     = 1'b1;
        n_mem_oe = 1'b0;
        mem_addr = {blk_q, idx[REG_AW-1:0]};
        // Read data lags the address by one cycle, so the write trails by one.
        if (idx != '0) begin
          rf_we    = 1'b1;
          rf_wsel  = idx[REG_AW-1:0] - REG_AW'(1);
          rf_wdata = mem_rdata;
        end
      end
      S_LOAD_DRAIN: begin
        busy     = 1'b1;
        rf_we    = 1'b1;
        rf_wsel  = '1;
        rf_wdata = mem_rdata;
      end
      S_DUMP_SEL: begin
        busy     = 1'b1;
        rf_rsel1 = idx[REG_AW-1:0];
        rf_rsel2 = idx[REG_AW-1:0] + HALF;
      end
      S_DUMP_OUT: begin
        busy       = 1'b1;
        dump_valid = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign err = err_q;

endmodule
